nios_cpu_nios2_cpu_mul_seq: RTL

// - Multi-cycle multiply sequencer placed in front of the CPU's 16x16 registered multiplier resource.
// - Accepts one 32x32 request per handshake and issues four 16x16 partial products, one per cycle.
// - Accumulates a 64-bit product and applies a signed correction.
// - Returns either the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS) to the A-stage writeback.

---
 rtl/nios_cpu_mul_pkg.sv | 30 +++
 rtl/nios_cpu_nios2_cpu_mul_pp16.sv | 30 +++
 rtl/nios_cpu_nios2_cpu_mul_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nios_cpu_mul_pkg.sv
`default_nettype none
// ============================================================================
// nios_cpu_mul_pkg
// Shared encodings for the sequential 32x32 multiplier (ops, states, shifts).
// Revision: 1.0
// ============================================================================
package nios_cpu_mul_pkg;

    localparam int HALF_W = 16;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd3;

    // Position of a partial product inside the 64-bit accumulator
    localparam logic [1:0] SH_0  = 2'd0;
    localparam logic [1:0] SH_16 = 2'd1;
    localparam logic [1:0] SH_32 = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nios_cpu_nios2_cpu_mul_pp16.sv
`default_nettype none
// ============================================================================
// nios_cpu_nios2_cpu_mul_pp16
// 16x16 unsigned multiplier with a single output register (1-cycle latency).
// Revision: 1.0
// ============================================================================
module nios_cpu_nios2_cpu_mul_pp16
    import nios_cpu_mul_pkg::*;
(
    input  logic                clk,
    input  logic                clr_n,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    logic [2*HALF_W-1:0] r_p;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_p <= '0;
        end else begin
            r_p <= (2*HALF_W)'(a) * (2*HALF_W)'(b);
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: rtl/nios_cpu_nios2_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
// nios_cpu_nios2_cpu_mul_seq
// Four-pass 32x32 multiply sequencer around one 16x16 registered multiplier.
// Revision: 1.0
// ============================================================================
module nios_cpu_nios2_cpu_mul_seq
    import nios_cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            r_op;
    logic [DATA_W-1:0]     r_src1;
    logic [DATA_W-1:0]     r_src2;
    logic [2*DATA_W-1:0]   r_acc;
    logic [2*DATA_W-1:0]   w_pp_shifted;
    logic [HALF_W-1:0]     w_sel_a;
    logic [HALF_W-1:0]     w_sel_b;
    logic [1:0]            w_sel_sh;
    logic [HALF_W-1:0]     r_iss_a;
    logic [HALF_W-1:0]     r_iss_b;
    logic [1:0]            r_iss_sh;
    logic                  r_iss_vld;
    logic                  r_iss_last;
    logic [1:0]            r_pp_sh;
    logic                  r_pp_vld;
    logic                  r_pp_last;
    logic [2*HALF_W-1:0]   w_pp;
    logic [DATA_W-1:0]     w_corr_a;
    logic [DATA_W-1:0]     w_corr_b;
    logic [DATA_W-1:0]     w_hi_fix;
    logic [DATA_W-1:0]     r_rsp_result;
    logic                  w_accept;
    logic                  w_pp_clr_n;
    logic                  w_sign_a;
    logic                  w_sign_b;

    assign req_ready  = reset_n && (r_state == IDLE);
    assign w_accept   = req_valid && req_ready && !flush;
    assign rsp_valid  = (r_state == DONE);
    assign rsp_result = r_rsp_result;
    assign w_pp_clr_n = reset_n && !flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN waits for the tagged final partial product to land in the accumulator
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MUL;
            MUL:     if (r_cnt == 2'd3) w_state_nxt = DRAIN;
            DRAIN:   if (r_pp_vld && r_pp_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_sel_a  = r_src1[HALF_W-1:0];
        w_sel_b  = r_src2[HALF_W-1:0];
        w_sel_sh = SH_0;
        case (r_cnt)
            2'd1: begin
                w_sel_a  = r_src1[DATA_W-1:HALF_W];
                w_sel_sh = SH_16;
            end
            2'd2: begin
                w_sel_b  = r_src2[DATA_W-1:HALF_W];
                w_sel_sh = SH_16;
            end
            2'd3: begin
                w_sel_a  = r_src1[DATA_W-1:HALF_W];
                w_sel_b  = r_src2[DATA_W-1:HALF_W];
                w_sel_sh = SH_32;
            end
            default: ;
        endcase
    end

    nios_cpu_nios2_cpu_mul_pp16 u_pp16 (
        .clk   (clk),
        .clr_n (w_pp_clr_n),
        .a     (r_iss_a),
        .b     (r_iss_b),
        .p     (w_pp)
    );

    always_comb begin
        w_pp_shifted = '0;
        case (r_pp_sh)
            SH_0:    w_pp_shifted = {{DATA_W{1'b0}}, w_pp};
            SH_16:   w_pp_shifted = {{HALF_W{1'b0}}, w_pp, {HALF_W{1'b0}}};
            SH_32:   w_pp_shifted = {w_pp, {DATA_W{1'b0}}};
            default: w_pp_shifted = '0;
        endcase
    end

    // Unsigned product is corrected to signed by subtracting the other operand per negative input
    assign w_sign_a = r_src1[DATA_W-1] && ((r_op == MUL_OP_MULXSU) || (r_op == MUL_OP_MULXSS));
    assign w_sign_b = r_src2[DATA_W-1] && (r_op == MUL_OP_MULXSS);
    assign w_corr_a = w_sign_a ? r_src2 : '0;
    assign w_corr_b = w_sign_b ? r_src1 : '0;
    assign w_hi_fix = r_acc[2*DATA_W-1:DATA_W] - w_corr_a - w_corr_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_acc        <= '0;
            r_iss_a      <= '0;
            r_iss_b      <= '0;
            r_iss_sh     <= SH_0;
            r_iss_vld    <= 1'b0;
            r_iss_last   <= 1'b0;
            r_pp_sh      <= SH_0;
            r_pp_vld     <= 1'b0;
            r_pp_last    <= 1'b0;
            r_rsp_result <= '0;
        end else if (flush) begin
            r_cnt      <= '0;
            r_iss_vld  <= 1'b0;
            r_iss_last <= 1'b0;
            r_pp_vld   <= 1'b0;
            r_pp_last  <= 1'b0;
        end else begin
            r_iss_a    <= w_sel_a;
            r_iss_b    <= w_sel_b;
            r_iss_sh   <= w_sel_sh;
            r_iss_vld  <= (r_state == MUL);
            r_iss_last <= (r_state == MUL) && (r_cnt == 2'd3);
            r_pp_sh    <= r_iss_sh;
            r_pp_vld   <= r_iss_vld;
            r_pp_last  <= r_iss_last;
            if (w_accept) begin
                r_op   <= req_op;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
                r_cnt  <= '0;
                r_acc  <= '0;
            end else begin
                if (r_state == MUL) begin
                    r_cnt <= r_cnt + 2'd1;
                end
                if (r_pp_vld) begin
                    r_acc <= r_acc + w_pp_shifted;
                end
            end
            if (r_state == FIX) begin
                r_rsp_result <= (r_op == MUL_OP_MUL) ? r_acc[DATA_W-1:0] : w_hi_fix;
            end
        end
    end

endmodule
`default_nettype wire
